// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: sequences load-use stalls, branch/jump redirects with
// flush bubbles, and halt, and counts the bubble cycles it inserts.
module fetch_sequencer #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  output logic        pc_mux_sel,
  output logic [15:0] jmp_loc,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] bubble_count
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    STALL    = 3'd1,
    REDIRECT = 3'd2,
    FLUSH    = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] jmp_loc_q, jmp_loc_d;
  logic        pc_mux_sel_q, stall_q, flush_q, halted_q;
  logic [15:0] bubble_q;

  logic        redirect_s;
  logic [15:0] target_s;

  // The branch is older than the jump in decode, so it wins when both fire.
  assign redirect_s = branch_taken | jump;
  assign target_s   = branch_taken ? branch_target : jump_target;

  // Next-state, counter and redirect-target selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    jmp_loc_d = jmp_loc_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect_s) begin
          state_d   = REDIRECT;
          jmp_loc_d = target_s;
          cnt_d     = 4'd0;
        end else if (load_use_hazard) begin
          state_d = STALL;
          cnt_d   = STALL_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      STALL, FLUSH: begin
        if (redirect_s) begin
          state_d   = REDIRECT;
          jmp_loc_d = target_s;
          cnt_d     = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the next state so they
  // change together with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 4'd0;
      jmp_loc_q    <= 16'h0000;
      pc_mux_sel_q <= 1'b0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      bubble_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      jmp_loc_q    <= jmp_loc_d;
      pc_mux_sel_q <= (state_d == REDIRECT);
      stall_q      <= (state_d == STALL) || (state_d == HALT);
      flush_q      <= (state_d == REDIRECT) || (state_d == FLUSH);
      halted_q     <= (state_d == HALT);
      if ((stall_q || flush_q) && (bubble_q != 16'hFFFF)) begin
        bubble_q <= bubble_q + 16'd1;
      end else begin
        bubble_q <= bubble_q;
      end
    end
  end

  assign pc_mux_sel   = pc_mux_sel_q;
  assign jmp_loc      = jmp_loc_q;
  assign stall        = stall_q;
  assign stall_pm     = stall_q;
  assign flush        = flush_q;
  assign halted       = halted_q;
  assign state        = state_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, async-reset and saturation
// sequences, then randomized traffic checked against a remaining-cycles model.
module tb_fetch_sequencer;

  localparam int S = 2;
  localparam int F = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt_req = 1'b0, resume = 1'b0, load_use_hazard = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0;
  logic [15:0] branch_target = 16'h0000, jump_target = 16'h0000;
  logic        pc_mux_sel, stall, stall_pm, flush, halted;
  logic [15:0] jmp_loc, bubble_count;
  logic [2:0]  state;

  fetch_sequencer #(.STALL_CYCLES(S), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .resume(resume),
    .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .stall(stall), .stall_pm(stall_pm),
    .flush(flush), .halted(halted), .state(state), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  wire [39:0] dut_o = {pc_mux_sel, jmp_loc, stall, stall_pm, flush, halted, state, bubble_count};

  function automatic logic [39:0] pk(input int s, input int pc, input int jl, input int st,
                                     input int fl, input int ha, input int bc);
    return {1'(pc), 16'(jl), 1'(st), 1'(st), 1'(fl), 1'(ha), 3'(s), 16'(bc)};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp_v);
    total++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %h expected %h (pc,jl,st,stpm,fl,ha,state,bc)", nm, act, exp_v);
    end else begin
      passed++;
    end
  endtask

  typedef struct packed {
    logic        hr, rs, hz, br;
    logic [15:0] bt;
    logic        jp;
    logic [15:0] jt;
    logic [39:0] exp_o;
  } vec_t;

  function automatic vec_t v(input int hr, input int rs, input int hz, input int br,
                             input int bt, input int jp, input int jt,
                             input int es, input int epc, input int ejl, input int est,
                             input int efl, input int eha, input int ebc);
    vec_t r;
    r.hr = 1'(hr); r.rs = 1'(rs); r.hz = 1'(hz); r.br = 1'(br);
    r.bt = 16'(bt); r.jp = 1'(jp); r.jt = 16'(jt);
    r.exp_o = pk(es, epc, ejl, est, efl, eha, ebc);
    return r;
  endfunction

  task automatic drive(input logic hr, input logic rs, input logic hz, input logic br,
                       input logic [15:0] bt, input logic jp, input logic [15:0] jt);
    halt_req = hr; resume = rs; load_use_hazard = hz;
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
  endtask

  // Reference model: pending work expressed as remaining bubble cycles.
  int          m_halt, m_redir, m_fl, m_sl, m_bc;
  logic [15:0] m_tgt;

  task automatic m_reset();
    m_halt = 0; m_redir = 0; m_fl = 0; m_sl = 0; m_bc = 0; m_tgt = 16'h0000;
  endtask

  function automatic logic [39:0] m_out();
    int s;
    s = (m_halt != 0) ? 4 : (m_redir != 0) ? 2 : (m_fl > 0) ? 3 : (m_sl > 0) ? 1 : 0;
    return pk(s, m_redir, int'(m_tgt), int'((m_halt != 0) || (m_sl > 0)),
              int'((m_redir != 0) || (m_fl > 0)), m_halt, m_bc);
  endfunction

  task automatic m_edge(input logic hr, input logic rs, input logic hz, input logic br,
                        input logic [15:0] bt, input logic jp, input logic [15:0] jt);
    logic        redir;
    logic [15:0] t;
    redir = br | jp;
    t = br ? bt : jt;
    if (((m_halt != 0) || (m_sl > 0) || (m_redir != 0) || (m_fl > 0)) && (m_bc < 65535)) m_bc++;
    if (m_halt != 0) begin
      if (rs) m_halt = 0;
    end else if (m_redir != 0) begin
      m_redir = 0; m_fl = F;
    end else if ((m_fl > 0) || (m_sl > 0)) begin
      if (redir) begin
        m_redir = 1; m_tgt = t; m_fl = 0; m_sl = 0;
      end else if (m_fl > 0) begin
        m_fl--;
      end else begin
        m_sl--;
      end
    end else if (hr) begin
      m_halt = 1;
    end else if (redir) begin
      m_redir = 1; m_tgt = t;
    end else if (hz) begin
      m_sl = S;
    end
  endtask

  vec_t tbl[31];

  initial begin
    logic hr, rs, hz, br, jp;
    logic [15:0] bt, jt;

    //        hr rs hz br bt      jp jt       st pc jl      st fl ha bc
    tbl[0]  = v(0, 0, 1, 0, 0,      0, 0,      1, 0, 'h0000, 1, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0,      0, 0,      1, 0, 'h0000, 1, 0, 0, 1);
    tbl[2]  = v(0, 0, 0, 0, 0,      0, 0,      0, 0, 'h0000, 0, 0, 0, 2);
    tbl[3]  = v(0, 0, 0, 0, 0,      1, 'h0040, 2, 1, 'h0040, 0, 1, 0, 2);
    tbl[4]  = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0040, 0, 1, 0, 3);
    tbl[5]  = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0040, 0, 1, 0, 4);
    tbl[6]  = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0040, 0, 1, 0, 5);
    tbl[7]  = v(0, 0, 0, 0, 0,      0, 0,      0, 0, 'h0040, 0, 0, 0, 6);
    tbl[8]  = v(0, 0, 0, 1, 'h0100, 1, 'h0200, 2, 1, 'h0100, 0, 1, 0, 6);
    tbl[9]  = v(1, 0, 1, 0, 0,      0, 0,      3, 0, 'h0100, 0, 1, 0, 7);
    tbl[10] = v(1, 0, 1, 0, 0,      0, 0,      3, 0, 'h0100, 0, 1, 0, 8);
    tbl[11] = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0100, 0, 1, 0, 9);
    tbl[12] = v(0, 0, 0, 0, 0,      0, 0,      0, 0, 'h0100, 0, 0, 0, 10);
    tbl[13] = v(1, 0, 1, 0, 0,      1, 'h0500, 4, 0, 'h0100, 1, 0, 1, 10);
    tbl[14] = v(1, 0, 0, 0, 0,      1, 'h0600, 4, 0, 'h0100, 1, 0, 1, 11);
    tbl[15] = v(1, 1, 0, 0, 0,      0, 0,      0, 0, 'h0100, 0, 0, 0, 12);
    tbl[16] = v(1, 0, 0, 0, 0,      0, 0,      4, 0, 'h0100, 1, 0, 1, 12);
    tbl[17] = v(0, 1, 0, 0, 0,      0, 0,      0, 0, 'h0100, 0, 0, 0, 13);
    tbl[18] = v(0, 0, 1, 0, 0,      0, 0,      1, 0, 'h0100, 1, 0, 0, 13);
    tbl[19] = v(0, 0, 0, 0, 0,      1, 'h0250, 2, 1, 'h0250, 0, 1, 0, 14);
    tbl[20] = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0250, 0, 1, 0, 15);
    tbl[21] = v(0, 0, 0, 1, 'h0300, 0, 0,      2, 1, 'h0300, 0, 1, 0, 16);
    tbl[22] = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0300, 0, 1, 0, 17);
    tbl[23] = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0300, 0, 1, 0, 18);
    tbl[24] = v(0, 0, 0, 0, 0,      0, 0,      3, 0, 'h0300, 0, 1, 0, 19);
    tbl[25] = v(0, 0, 0, 0, 0,      0, 0,      0, 0, 'h0300, 0, 0, 0, 20);
    tbl[26] = v(0, 0, 1, 0, 0,      0, 0,      1, 0, 'h0300, 1, 0, 0, 20);
    tbl[27] = v(1, 0, 0, 0, 0,      0, 0,      1, 0, 'h0300, 1, 0, 0, 21);
    tbl[28] = v(1, 0, 0, 0, 0,      0, 0,      0, 0, 'h0300, 0, 0, 0, 22);
    tbl[29] = v(1, 0, 0, 0, 0,      0, 0,      4, 0, 'h0300, 1, 0, 1, 22);
    tbl[30] = v(0, 1, 0, 0, 0,      0, 0,      0, 0, 'h0300, 0, 0, 0, 23);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", dut_o, pk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].hr, tbl[i].rs, tbl[i].hz, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt);
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d]", i), dut_o, tbl[i].exp_o);
    end

    // Asynchronous reset in the middle of a flush.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(posedge clk); #1;
    chk("pre_rst_flush", 40'(state), 40'(3));
    #2 reset = 1'b1;
    #1 chk("async_rst_flush", dut_o, pk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Asynchronous reset in the middle of a halt.
    halt_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_halt", 40'(halted), 40'(1));
    #2 reset = 1'b1;
    #1 chk("async_rst_halt", dut_o, pk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Long halt drives bubble_count into saturation.
    repeat (65600) @(posedge clk);
    #1;
    chk("sat_halt", dut_o, pk(4, 0, 0, 1, 0, 1, 'hFFFF));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(posedge clk); #1;
    chk("sat_resume", dut_o, pk(0, 0, 0, 0, 0, 0, 'hFFFF));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 40'(bubble_count), 40'(16'hFFFF));

    // Randomized traffic against the reference model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 2500; i++) begin
      hr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 4) == 0);
      hz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 7) == 0);
      jp = ($urandom_range(0, 7) == 0);
      bt = 16'($urandom);
      jt = 16'($urandom);
      drive(hr, rs, hz, br, bt, jp, jt);
      m_edge(hr, rs, hz, br, bt, jp, jt);
      @(posedge clk); #1;
      chk($sformatf("random[%0d]", i), dut_o, m_out());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
